sram_access_controller: RTL and testbench

//  Sequences every MEM-stage load/store onto the external 16-bit asynchronous SRAM.

---
 rtl/sram_access_controller.sv | 130 +++++++++++++
 tb/tb_sram_access_controller.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/sram_access_controller.sv
// sram_access_controller: MEM-stage load/store sequencer for a 16-bit async SRAM.
// Ports: clk/rst, rd_en/wr_en/address/write_data in, read_data/ready out, sram_* pins.
module sram_access_controller #(
    parameter int WAIT_CYCLES = 5,
    parameter int BASE_ADDR   = 1024,
    parameter int SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    inout  wire  [15:0]        sram_dq,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic               sram_we_n,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_ub_n,
    output logic               sram_lb_n
);

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        DONE
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [SRAM_AW-2:0] pair_q, pair_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               wr_q, wr_d;
    logic [31:0]        rdata_q, rdata_d;

    logic [31:0] offset;
    logic        req;
    logic        last;
    logic        busy;

    assign req    = rd_en | wr_en;
    assign offset = address - 32'(BASE_ADDR);
    assign last   = (cnt_q == LAST_CNT);
    assign busy   = (state_q == LOW) || (state_q == HIGH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pair_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pair_q  <= pair_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pair_d  = pair_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    // Only the 32-bit word index is kept; the phase
                    // supplies the SRAM address LSB.
                    pair_d  = offset[SRAM_AW:2];
                    wdata_d = write_data;
                    wr_d    = wr_en;
                    cnt_d   = '0;
                    state_d = LOW;
                end
            end
            LOW: begin
                cnt_d = cnt_q + 4'd1;
                if (last) begin
                    cnt_d   = '0;
                    state_d = HIGH;
                    if (!wr_q) rdata_d[15:0] = sram_dq;
                end
            end
            HIGH: begin
                cnt_d = cnt_q + 4'd1;
                if (last) begin
                    cnt_d   = '0;
                    state_d = DONE;
                    if (!wr_q) rdata_d[31:16] = sram_dq;
                end
            end
            DONE: begin
                // No restart here: the pipeline advances this cycle.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign read_data = rdata_q;
    assign ready     = (state_q == IDLE) ? ~req : (state_q == DONE);

    // Strobe released on the final phase cycle while data stays driven,
    // giving the SRAM hold time on the rising edge of we_n.
    assign sram_we_n = ~(wr_q & busy & ~last);
    assign sram_addr = busy ? {pair_q, state_q == HIGH} : '0;
    assign sram_dq   = (wr_q && busy)
                     ? ((state_q == HIGH) ? wdata_q[31:16] : wdata_q[15:0])
                     : 16'bz;

    assign sram_ce_n = 1'b0;
    assign sram_oe_n = 1'b0;
    assign sram_ub_n = 1'b0;
    assign sram_lb_n = 1'b0;

endmodule

// File: tb/tb_sram_access_controller.sv
// tb_sram_access_controller: directed bench with a behavioural 16-bit SRAM.
// Checks reset, write/read sequencing, latency, priority and async reset.
module tb_sram_access_controller;

    logic        clk;
    logic        rst;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        sram_we_n;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_ub_n;
    logic        sram_lb_n;

    int n_checks = 0;
    int n_fail   = 0;

    logic        rd_mode = 1'b0;
    logic [15:0] mem [0:15] = '{default: 16'h0000};

    sram_access_controller dut (
        .clk        (clk),
        .rst        (rst),
        .rd_en      (rd_en),
        .wr_en      (wr_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .sram_dq    (sram_dq),
        .sram_addr  (sram_addr),
        .sram_we_n  (sram_we_n),
        .sram_ce_n  (sram_ce_n),
        .sram_oe_n  (sram_oe_n),
        .sram_ub_n  (sram_ub_n),
        .sram_lb_n  (sram_lb_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!sram_we_n) mem[sram_addr[3:0]] <= sram_dq;
    end

    assign sram_dq = rd_mode ? mem[sram_addr[3:0]] : 16'bz;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic w, input logic r, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] lo);
        wr_en      = w;
        rd_en      = r;
        address    = a;
        write_data = d;
        #1;
        chk("ready_c0", 32'(ready), 32'd0);
        for (int k = 1; k <= 11; k++) begin
            tick();
            chk("ready_cyc", 32'(ready), 32'(k == 11));
            chk("we_n_cyc", 32'(sram_we_n), 32'(!w || k == 5 || k >= 10));
            if (k == 1) chk("addr_lo", 32'(sram_addr), lo);
            if (k == 6) chk("addr_hi", 32'(sram_addr), lo + 32'd1);
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        tick();
        chk("ready_idle", 32'(ready), 32'd1);
    endtask

    initial begin
        rst        = 1'b1;
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        address    = '0;
        write_data = '0;
        tick();
        tick();
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_we_n", 32'(sram_we_n), 32'd1);
        chk("rst_addr", 32'(sram_addr), 32'd0);
        chk("rst_rdata", read_data, 32'd0);
        chk("ties", 32'({sram_ce_n, sram_oe_n, sram_ub_n, sram_lb_n}), 32'd0);
        rd_en = 1'b1;
        #1;
        chk("rst_ready_req", 32'(ready), 32'd0);
        rd_en = 1'b0;
        rst   = 1'b0;
        tick();

        // 1: write 0x12345678 at base
        run(1'b1, 1'b0, 32'd1024, 32'h1234_5678, 32'd0);
        chk("t1_w0", 32'(mem[0]), 32'h5678);
        chk("t1_w1", 32'(mem[1]), 32'h1234);

        // 2: read it back
        rd_mode = 1'b1;
        run(1'b0, 1'b1, 32'd1024, 32'h0, 32'd0);
        rd_mode = 1'b0;
        chk("t2_rdata", read_data, 32'h1234_5678);

        // 3: write at 1028 -> words 2/3
        run(1'b1, 1'b0, 32'd1028, 32'hDEAD_BEEF, 32'd2);
        chk("t3_w2", 32'(mem[2]), 32'hBEEF);
        chk("t3_w3", 32'(mem[3]), 32'hDEAD);
        chk("t3_rdata", read_data, 32'h1234_5678);

        // 4: both requests -> write wins
        run(1'b1, 1'b1, 32'd1032, 32'hA5A5_0F0F, 32'd4);
        chk("t4_w4", 32'(mem[4]), 32'h0F0F);
        chk("t4_w5", 32'(mem[5]), 32'hA5A5);
        chk("t4_rdata", read_data, 32'h1234_5678);

        // 5: async reset in cycle 3 of a write
        wr_en      = 1'b1;
        address    = 32'd1040;
        write_data = 32'hCAFE_F00D;
        tick();
        tick();
        tick();
        chk("t5_we_before", 32'(sram_we_n), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_we_n", 32'(sram_we_n), 32'd1);
        chk("t5_addr", 32'(sram_addr), 32'd0);
        chk("t5_ready_req", 32'(ready), 32'd0);
        chk("t5_rdata", read_data, 32'd0);
        wr_en = 1'b0;
        #1;
        chk("t5_ready", 32'(ready), 32'd1);
        rst = 1'b0;
        tick();
        chk("t5_idle", 32'(ready), 32'd1);
        chk("t5_w8", 32'(mem[8]), 32'hF00D);
        chk("t5_w9", 32'(mem[9]), 32'h0000);

        // 6: back-to-back reads, request held across DONE
        rd_mode = 1'b1;
        rd_en   = 1'b1;
        address = 32'd1024;
        #1;
        chk("t6_ready_c0", 32'(ready), 32'd0);
        for (int k = 1; k <= 23; k++) begin
            tick();
            chk("t6_ready", 32'(ready), 32'(k == 11 || k == 23));
            chk("t6_we_n", 32'(sram_we_n), 32'd1);
            if (k == 11) begin
                chk("t6_rdata1", read_data, 32'h1234_5678);
                address = 32'd1028;
            end
        end
        chk("t6_rdata2", read_data, 32'hDEAD_BEEF);
        rd_en = 1'b0;
        tick();
        rd_mode = 1'b0;
        chk("t6_idle", 32'(ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
